// File: rtl/avr_fetch.sv
// Fetch/sequencing for the growl AVR core: owns PC, drives 1-cycle sync imem, feeds decoder.
// Fetch-to-decode latency 1 cycle; c_pc_stall holds PC and instruction, skips cost one squashed cycle.
module avr_fetch #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [15:0]     inst,
    output logic [1:0]      state,
    output logic [15:0]     k_word,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] ret_pc,
    output logic            skipping,
    input  logic [2:0]      c_pc_next,
    input  logic            c_pc_offset_mode,
    input  logic            branch_taken,
    input  logic            c_pc_stall,
    input  logic [1:0]      c_next_state,
    input  logic            c_skip,
    input  logic [15:0]     z_addr,
    input  logic [PC_W-1:0] stack_pc
);

    logic [PC_W-1:0] r_pc;
    logic [1:0]      r_state;
    logic [15:0]     r_inst_q;
    logic            r_skip_q;
    logic            r_stall_q;

    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_rel_off;
    logic [21:0]     w_abs;
    logic [15:0]     w_inst;
    logic [1:0]      w_state_nxt;
    logic            w_skip_nxt;
    logic            w_two_word;

    assign w_pc_inc = r_pc + PC_W'(1);

    // JMP/CALL and LDS/STS carry a second word that must be skipped along with the first.
    assign w_two_word = ((imem_data[15:9] == 7'b1001010) && (imem_data[3:2] == 2'b11)) ||
                        ((imem_data[15:10] == 6'b100100) && (imem_data[3:0] == 4'b0000));

    assign w_rel_off = c_pc_offset_mode
                     ? (branch_taken ? {{(PC_W-7){w_inst[9]}}, w_inst[9:3]} : '0)
                     : {{(PC_W-12){w_inst[11]}}, w_inst[11:0]};

    assign w_abs = {w_inst[8:4], w_inst[0], imem_data};

    always_comb begin
        w_inst = imem_data;
        if (rst || r_skip_q) begin
            w_inst = 16'h0000;
        end else if ((r_state != 2'd0) || r_stall_q) begin
            w_inst = r_inst_q;
        end
    end

    always_comb begin
        w_pc_next   = w_pc_inc;
        w_state_nxt = c_next_state;
        w_skip_nxt  = 1'b0;
        if (rst) begin
            w_pc_next   = RESET_VEC;
            w_state_nxt = 2'd0;
        end else if (c_pc_stall) begin
            w_pc_next  = r_pc;
            w_skip_nxt = r_skip_q;
        end else if (r_skip_q) begin
            w_pc_next   = w_two_word ? (r_pc + PC_W'(2)) : w_pc_inc;
            w_state_nxt = 2'd0;
        end else begin
            case (c_pc_next)
                3'd1:    w_pc_next = w_pc_inc + w_rel_off;
                3'd2:    w_pc_next = PC_W'(w_abs);
                3'd3:    w_pc_next = PC_W'(z_addr);
                3'd4:    w_pc_next = stack_pc;
                default: begin
                    w_pc_next  = w_pc_inc;
                    w_skip_nxt = c_skip;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_VEC;
            r_state   <= 2'd0;
            r_inst_q  <= 16'h0000;
            r_skip_q  <= 1'b0;
            r_stall_q <= 1'b0;
        end else begin
            r_pc      <= w_pc_next;
            r_state   <= w_state_nxt;
            r_inst_q  <= w_inst;
            r_skip_q  <= w_skip_nxt;
            r_stall_q <= c_pc_stall;
        end
    end

    assign imem_addr = w_pc_next;
    assign inst      = w_inst;
    assign state     = r_state;
    assign k_word    = imem_data;
    assign pc        = r_pc;
    assign ret_pc    = rst ? (RESET_VEC + PC_W'(1)) : w_pc_inc;
    assign skipping  = r_skip_q & ~c_pc_stall & ~rst;

endmodule

// File: doc/avr_fetch.md
# avr_fetch

Instruction fetch and sequencing unit for the growl AVR core. It owns the program counter, drives the synchronous instruction memory, and presents `inst` and `state` to the instruction decoder. It consumes the decoder's sequencing outputs (`c_pc_next`, `c_pc_stall`, `c_next_state`, `c_skip`, `c_pc_offset_mode`) to compute the next fetch address. It implements skip-next-instruction, including skipping a two-word instruction as a single instruction.

## Interface
- `PC_W`, 16: width of the program counter and of word addresses into instruction memory.
- `RESET_VEC`, 0: word address fetched out of reset.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_addr` output PC_W: word address to instruction memory. Memory is synchronous with 1-cycle read latency.
- `imem_data` input 16: memory word for the `imem_addr` presented in the previous cycle.
- `inst` output 16: instruction word to the decoder.
- `state` output 2: decoder phase register.
- `k_word` output 16: raw `imem_data`, used as the second word of JMP, CALL, LDS and STS.
- `pc` output PC_W: word address currently on `imem_data`.
- `ret_pc` output PC_W: `pc+1`; this is the return address pushed by RCALL, CALL and ICALL.
- `skipping` output 1: high in the cycle a skipped word is being squashed.
- `c_pc_next` input 3: next-PC source.
  - 0 = INC
  - 1 = REL
  - 2 = ABS
  - 3 = Z
  - 4 = STACK
  - 5–7 = INC
- `c_pc_offset_mode` input 1: REL offset format. 0 = 12-bit `inst[11:0]` (RJMP/RCALL); 1 = 7-bit `inst[9:3]` (BRxx).
- `branch_taken` input 1: BRxx condition result. Used only when REL and offset mode is 1.
- `c_pc_stall` input 1: hold PC and instruction.
- `c_next_state` input 2: next value of `state`.
- `c_skip` input 1: skip condition true; the next instruction is to be skipped.
- `z_addr` input 16: Z register, used for IJMP/ICALL.
- `stack_pc` input PC_W: popped return address, used for RET/RETI.

## Operation
Registers: `pc`, `state`, `inst_q`, `skip_q`.

`pc_next` is computed combinationally. `imem_addr` = `pc_next` (or `RESET_VEC` during `rst`). The next cycle, `pc` <= `pc_next` and `imem_data` = mem[`pc`]. Consequently a taken jump costs no fetch bubble.

`inst` is selected combinationally, in this order:
- `rst` → `16'h0000`
- `skip_q` → `16'h0000` (NOP)
- `state`≠0 or the previous cycle stalled → `inst_q`
- otherwise → `imem_data`

`inst_q` <= `inst` every cycle in which `inst` is not `inst_q`.

`pc_next` priority, highest first:
1. `rst`: `RESET_VEC`.
2. `c_pc_stall`: `pc`. `state` <= `c_next_state`. `skip_q` is unchanged and `c_skip` is ignored.
3. `skip_q`: the word on `imem_data` is the skipped instruction.
   - `pc+2` if that word is two-word, otherwise `pc+1`.
   - Two-word means `imem_data[15:9]`=`1001010` with `[3:2]`=`11` (JMP/CALL), or `imem_data[15:10]`=`100100` with `[3:0]`=`0000` (LDS/STS).
   - `state` <= 0 and `skip_q` <= 0. All decoder outputs are ignored this cycle.
4. `c_pc_next`:
   - INC: `pc+1`.
   - REL: `pc+1+sext(off)`. With `c_pc_offset_mode`=1 and `branch_taken`=0 this is `pc+1`.
   - ABS: `{inst[8:4], inst[0], imem_data}`, truncated to `PC_W`.
   - Z: `z_addr` (zero-extended or truncated to `PC_W`).
   - STACK: `stack_pc`.
   - In all cases `state` <= `c_next_state`.
   - `skip_q` <= `c_skip` only when `c_pc_next` is INC. A taken jump drops the skip.

Arithmetic: all PC arithmetic is modulo 2^`PC_W`, and offsets are sign-extended. `pc` = 2^`PC_W`−1 with INC wraps to 0.

Two-word instructions:
- In state 0 the decoder issues INC with `c_next_state`=1.
- In state 1, `k_word` holds the second word and `inst` holds the first word (from `inst_q`).

## Timing
- Reset values: `pc`=`RESET_VEC`, `state`=0, `inst_q`=0, `skip_q`=0, `skipping`=0. While `rst` is high: `imem_addr`=`RESET_VEC`, `inst`=0, `ret_pc`=`RESET_VEC`+1.
- First cycle after `rst` falls: `inst` = mem[`RESET_VEC`] with no bubble, provided `rst` was high for at least 1 cycle.
- Fetch-to-decode latency is 1 cycle, and throughput is 1 instruction per cycle.
- `skipping` = `skip_q` & ~`c_pc_stall`.
- A skip costs 1 cycle, whether the skipped instruction is one word or two.
- `rst` asserted mid-instruction (`state`≠0 or `skip_q`=1) aborts it; the next cycle matches the reset values.

## Test plan
- Reset then sequential fetch from a memory of ascending words (mem[i]=`16'h1000`+i): after `rst` falls, `inst` = `1000`, `1001`, `1002` on consecutive cycles; `imem_addr` = 1, 2, 3.
- RJMP −1 (`C FFF`) at address 5: the next cycle `pc`=5 and `inst`=`CFFF` again (tight loop). BRNE +2 at address 8 with `branch_taken`=1: `pc`=11. The same BRNE with `branch_taken`=0: `pc`=9.
- JMP at address 2 (`940C`, second word `0040`): state 0 → 1 with `inst`=`940C` and `k_word`=`0040`; then `pc`=`0x40` and `state`=0.
- CPSE at address 3 with `c_skip`=1, next word STS (`9200`, two words): `skipping`=1 for one cycle, `inst`=0, then `pc`=6.
- `c_pc_stall` held for 2 cycles in state 1: `pc`, `inst` and `imem_addr` are stable; a `c_skip` pulse during the stall produces no skip.
- `rst` asserted while `state`=1 and `skip_q`=1: the next cycle `pc`=`RESET_VEC`, `state`=0, `skipping`=0.
